// File: rtl/data_mem_responder.sv
// Slow data-memory responder: one request at a time over req/ack, completed after LATENCY edges.
// Optional DMEM_BYTE_MASK_EN adds a be_i byte-enable port for partial-word writes.
module data_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef DMEM_BYTE_MASK_EN
  input  logic [DATA_W/8-1:0] be_i,
`endif
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int BE_W   = DATA_W / 8;
  localparam int WIDX_W = ADDR_W - 2;
  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [7:0]        CNT_LOAD = 8'(LATENCY - 1);
  localparam logic [WIDX_W-1:0] DEPTH_C  = WIDX_W'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                accept;
  logic                we_q;
  logic [WIDX_W-1:0]   widx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem_q [DEPTH_WORDS];
  logic                access;
  logic                in_range;
  logic                mem_wr_en;
  logic [IDX_W-1:0]    mem_idx;
  logic [BE_W-1:0]     wr_be;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];

`ifdef DMEM_BYTE_MASK_EN
  assign wr_be = be_i;
`else
  assign wr_be = '1;
`endif

  // Range check and storage index come from the latched request, never from live inputs.
  assign in_range  = (widx_q < DEPTH_C);
  assign mem_idx   = widx_q[IDX_W-1:0];
  assign access    = (state_q == S_WAIT) && (cnt_q == 8'd0);
  assign mem_wr_en = access && we_q && in_range;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (req_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      we_q    <= we_i;
      widx_q  <= addr_i[ADDR_W-1:2];
      wdata_q <= wdata_i;
      be_q    <= wr_be;
    end
  end

  // Storage has no reset; a reset clears state_q, which blocks the pending write.
  always_ff @(posedge clk_i) begin
    if (mem_wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_q[b]) begin
          mem_q[mem_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (access && !we_q) begin
      rdata_q <= in_range ? mem_q[mem_idx] : '0;
    end
  end

  assign ack_o   = (state_q == S_DONE);
  assign busy_o  = (state_q == S_WAIT);
  assign err_o   = (state_q == S_DONE) && !in_range;
  assign rdata_o = rdata_q;

endmodule
